// File: rtl/ex_csa_pkg.sv
// Shared definitions for the carry-save accumulator slice.
package ex_csa_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      OUTPUT  = 2'd2
   } stateT;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 16;

   localparam logic [7:0] COUNT_MAX = 8'd255;

endpackage

// File: rtl/ex_csa_row.sv
// Combinational 3:2 carry-save row: sumVec + carryVec == a + b + c (mod 2^WIDTH).
module ex_csa_row
   import ex_csa_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] sumVec,
   output logic [WIDTH-1:0] carryVec
);

   logic [WIDTH-1:0] maj;

   for (genvar g = 0; g < WIDTH / 2; g++) begin : gCell
      assign sumVec[2*g +: 2] = a[2*g +: 2] ^ b[2*g +: 2] ^ c[2*g +: 2];
      assign maj[2*g +: 2]    = (a[2*g +: 2] & b[2*g +: 2])
                              | (a[2*g +: 2] & c[2*g +: 2])
                              | (b[2*g +: 2] & c[2*g +: 2]);
   end

   if (WIDTH % 2 != 0) begin : gTail
      assign sumVec[WIDTH-1] = a[WIDTH-1] ^ b[WIDTH-1] ^ c[WIDTH-1];
      assign maj[WIDTH-1]    = (a[WIDTH-1] & b[WIDTH-1]) | (a[WIDTH-1] & c[WIDTH-1])
                             | (b[WIDTH-1] & c[WIDTH-1]);
   end

   // Majority of the top bit falls off: the pair is only valid mod 2^WIDTH.
   assign carryVec = maj << 1;

endmodule

// File: rtl/ex_csa_accum_seq.sv
// Carry-save group accumulator; the redundant sum is resolved one CHUNK slice per cycle.
module ex_csa_accum_seq
   import ex_csa_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [7:0]       out_count
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   stateT            state;
   stateT            stateNext;
   logic [WIDTH-1:0] sumReg;
   logic [WIDTH-1:0] carryReg;
   logic [WIDTH-1:0] rowSum;
   logic [WIDTH-1:0] rowCarry;
   logic [WIDTH-1:0] result;
   logic [7:0]       count;
   logic [IDXW-1:0]  chunkIdx;
   logic             chunkCarry;
   logic             accept;
   logic             lastChunk;
   logic [CHUNK:0]   sliceAdd;

   ex_csa_row #(.WIDTH(WIDTH)) uRow (
      .a        (sumReg),
      .b        (carryReg),
      .c        (in_data),
      .sumVec   (rowSum),
      .carryVec (rowCarry)
   );

   assign accept    = in_valid && in_ready;
   assign lastChunk = (chunkIdx == IDXW'(NCHUNK - 1));
   assign sliceAdd  = {1'b0, sumReg[chunkIdx*CHUNK +: CHUNK]}
                    + {1'b0, carryReg[chunkIdx*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, chunkCarry};

   assign out_data  = result;
   assign out_count = count;

   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (accept && in_last) stateNext = RESOLVE;
         end
         RESOLVE: begin
            if (lastChunk) stateNext = OUTPUT;
         end
         OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) stateNext = ACCUM;
         end
         default: stateNext = ACCUM;
      endcase
      if (abort) stateNext = ACCUM;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ACCUM;
         sumReg     <= '0;
         carryReg   <= '0;
         count      <= '0;
         result     <= '0;
         chunkIdx   <= '0;
         chunkCarry <= 1'b0;
      end else begin
         state <= stateNext;
         if (abort) begin
            sumReg     <= '0;
            carryReg   <= '0;
            count      <= '0;
            result     <= '0;
            chunkIdx   <= '0;
            chunkCarry <= 1'b0;
         end else begin
            case (state)
               ACCUM: begin
                  chunkIdx   <= '0;
                  chunkCarry <= 1'b0;
                  if (accept) begin
                     sumReg   <= rowSum;
                     carryReg <= rowCarry;
                     count    <= (count == COUNT_MAX) ? count : count + 8'd1;
                  end
               end
               RESOLVE: begin
                  // Carry out of the top slice wraps away and is cleared again in ACCUM.
                  result[chunkIdx*CHUNK +: CHUNK] <= sliceAdd[CHUNK-1:0];
                  chunkCarry                      <= sliceAdd[CHUNK];
                  chunkIdx                        <= lastChunk ? '0 : chunkIdx + 1'b1;
               end
               OUTPUT: begin
                  if (out_ready) begin
                     sumReg   <= '0;
                     carryReg <= '0;
                     count    <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_csa_accum_seq.sv
// Scoreboard bench: group sums from plain modular addition, checked by an independent monitor.
module tb_ex_csa_accum_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        abort = 1'b0;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] sum;
      logic [7:0]  cnt;
   } expT;

   expT         expQ[$];
   expT         monExp;
   logic [31:0] modelSum = '0;
   int          modelCnt = 0;
   int          sinkMode = 0;

   ex_csa_accum_seq #(.WIDTH(32), .CHUNK(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Consumer: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #2;
         case (sinkMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: an abort drops whatever group is outstanding; a handshake retires one entry.
   initial begin
      forever begin
         @(negedge clock);
         if (reset && abort) begin
            expQ.delete();
         end else if (reset && out_valid) begin
            check("ready_while_valid", in_ready, 0);
            if (out_ready) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got data 0x%0h count %0d, none expected",
                           out_data, out_count);
               end else begin
                  monExp = expQ.pop_front();
                  check("out_data", out_data, monExp.sum);
                  check("out_count", out_count, monExp.cnt);
               end
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic sendBeat(input logic [31:0] d, input logic last);
      bit done = 0;
      int waitN = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!done) begin
         @(negedge clock);
         if (in_ready) begin
            done = 1;
            modelSum = modelSum + d;
            if (modelCnt < 255) modelCnt++;
            if (last) begin
               expQ.push_back('{sum: modelSum, cnt: 8'(modelCnt)});
               modelSum = '0;
               modelCnt = 0;
            end
         end else if (++waitN > 50) begin
            done = 1;
            check("in_ready_timeout", 0, 1);
         end
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = $urandom();
   endtask

   task automatic waitValid(input int maxC);
      bit ok = 0;
      for (int i = 0; i < maxC; i++) begin
         @(negedge clock);
         if (out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("out_valid_timeout", 0, 1);
   endtask

   task automatic doAbort();
      abort    = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = $urandom();
      @(negedge clock);
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      modelSum = '0;
      modelCnt = 0;
   endtask

   initial begin
      logic [31:0] holdData;
      logic [7:0]  holdCount;
      int          len;
      logic [31:0] d;

      #12;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_count", out_count, 0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      // Single beat: latency and ready behaviour.
      sendBeat(32'h5, 1'b1);
      @(negedge clock);
      check("ready_low_after_last", in_ready, 0);
      check("valid_low_t1", out_valid, 0);
      @(negedge clock);
      check("valid_low_t2", out_valid, 0);
      @(negedge clock);
      check("valid_high_t3", out_valid, 1);
      tick();
      @(negedge clock);
      check("ready_after_handshake", in_ready, 1);
      tick();

      // Inter-chunk carry and wrap-around.
      sendBeat(32'h0000_FFFF, 1'b0);
      sendBeat(32'h0000_0001, 1'b1);
      waitValid(10);
      tick();
      sendBeat(32'hFFFF_FFFF, 1'b0);
      sendBeat(32'h0000_0001, 1'b0);
      sendBeat(32'h8000_0000, 1'b1);
      waitValid(10);
      tick();

      // Stalled consumer: output must hold.
      sinkMode = 2;
      sendBeat(32'h1234, 1'b0);
      sendBeat(32'h1111, 1'b1);
      waitValid(10);
      holdData  = out_data;
      holdCount = out_count;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("hold_data", out_data, holdData);
         check("hold_count", out_count, holdCount);
         check("hold_ready_low", in_ready, 0);
         check("hold_valid", out_valid, 1);
      end
      tick();
      sinkMode = 0;
      @(negedge clock);
      check("ready_during_handshake", in_ready, 0);
      tick();
      @(negedge clock);
      check("ready_after_stall", in_ready, 1);
      tick();

      // Abort mid-group, with a coincident last beat discarded.
      sendBeat(32'h10, 1'b0);
      sendBeat(32'h20, 1'b0);
      doAbort();
      @(negedge clock);
      check("abort_ready", in_ready, 1);
      check("abort_no_valid", out_valid, 0);
      tick();
      sendBeat(32'h7, 1'b1);
      waitValid(10);
      tick();

      // Abort coincident with the output handshake.
      sinkMode = 2;
      sendBeat(32'h5, 1'b1);
      waitValid(10);
      tick();
      sinkMode = 0;
      doAbort();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("abort_drops_result", out_valid, 0);
      end
      check("abort_clears_result", out_data, 0);
      check("abort_clears_count", out_count, 0);
      tick();
      sendBeat(32'h9, 1'b1);
      waitValid(10);
      tick();

      // Reset during RESOLVE.
      sendBeat(32'h55, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("reset_mid_valid", out_valid, 0);
      check("reset_mid_ready", in_ready, 1);
      check("reset_mid_count", out_count, 0);
      expQ.delete();
      modelSum = '0;
      modelCnt = 0;
      @(negedge clock);
      reset = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("no_partial_result", out_valid, 0);
      end
      tick();
      sendBeat(32'h3, 1'b0);
      sendBeat(32'h4, 1'b1);
      waitValid(10);
      tick();

      // Count saturation.
      for (int i = 0; i < 300; i++) sendBeat(32'h1, (i == 299));
      waitValid(10);
      tick();

      // Randomized groups with a random consumer and occasional aborts.
      sinkMode = 1;
      for (int g = 0; g < 40; g++) begin
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) tick();
            if ($urandom_range(0, 24) == 0) doAbort();
            case ($urandom_range(0, 3))
               0:       d = 32'hFFFF_FFFF;
               1:       d = 32'h0000_FFFF;
               default: d = $urandom();
            endcase
            sendBeat(d, (b == len - 1));
         end
      end

      sinkMode = 0;
      for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
      check("drain", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
